// File: rtl/mult_shift_add.sv
// Sequential unsigned shift-and-add multiplier driving an external ripple-carry adder.
// One partial product is folded in per cycle; a WIDTH x WIDTH product takes WIDTH iterations.
module mult_shift_add #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   add_num1,
    output logic [WIDTH-1:0]   add_num2,
    input  logic [WIDTH-1:0]   add_resul,
    input  logic               add_cout,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic                accept;
    logic                last_iter;
    logic [WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]    acc_hi;
    logic [WIDTH-1:0]    acc_lo;
    logic [CW-1:0]       cnt;
    logic [2*WIDTH-1:0]  acc_shifted;

    assign last_iter   = (cnt == CW'(WIDTH - 1));
    // Carry-out lands in the accumulator MSB, so the shifted sum never overflows.
    assign acc_shifted = {add_cout, add_resul, acc_lo[WIDTH-1:1]};

    assign add_num1 = acc_hi;
    assign add_num2 = acc_lo[0] ? mcand : '0;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mcand  <= a;
                acc_hi <= '0;
                acc_lo <= b;
                cnt    <= '0;
            end else if (state == RUN) begin
                {acc_hi, acc_lo} <= acc_shifted;
                cnt              <= cnt + CW'(1);
                if (last_iter) begin
                    product <= acc_shifted;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_shift_add.sv
// Bench for mult_shift_add: a behavioural adder closes the loop, products are checked
// against plain a*b arithmetic for directed and random operands.
module tb_mult_shift_add;

    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   add_num1;
    logic [WIDTH-1:0]   add_num2;
    logic [WIDTH-1:0]   add_resul;
    logic               add_cout;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int n_cmp = 0;
    int n_err = 0;

    // Stand-in for the attached ripple-carry adder.
    assign {add_cout, add_resul} = {1'b0, add_num1} + {1'b0, add_num2};

    mult_shift_add #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .add_num1 (add_num1),
        .add_num2 (add_num2),
        .add_resul(add_resul),
        .add_cout (add_cout),
        .busy     (busy),
        .done     (done),
        .product  (product)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: present operands with start high.
    task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_);
        a     = ta;
        b     = tb_;
        start = 1'b1;
    endtask

    // Runs from the accepting edge through the DONE cycle, leaving the bench at the
    // DONE-cycle negedge with start low. Optionally pokes start mid-run.
    task automatic run_body(input string tag, input logic [2*WIDTH-1:0] exp,
                            input bit mid_start, input bit b_zero, output bit carry_seen);
        carry_seen = 1'b0;
        @(posedge clk);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            start = 1'b0;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            if (b_zero) chk({tag, "_num2zero"}, 32'(add_num2), 32'd0);
            if (add_cout) carry_seen = 1'b1;
            if (mid_start && i == 1) begin
                a     = ~a;
                b     = ~b;
                start = 1'b1;
            end
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_donebusy"}, 32'(busy), 32'd0);
        chk({tag, "_product"}, 32'(product), 32'(exp));
    endtask

    task automatic single_op(input string tag, input logic [WIDTH-1:0] ta,
                             input logic [WIDTH-1:0] tb_, input bit mid_start);
        bit c;
        logic [2*WIDTH-1:0] exp;
        exp = (2*WIDTH)'(ta) * (2*WIDTH)'(tb_);
        launch(ta, tb_);
        run_body(tag, exp, mid_start, (tb_ == '0), c);
        @(negedge clk);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, 32'(product), 32'(exp));
    endtask

    initial begin
        bit carry;
        logic [WIDTH-1:0] ra, rb;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_num1", 32'(add_num1), 32'd0);
        chk("rst_num2", 32'(add_num2), 32'd0);

        launch(4'hF, 4'hF);
        run_body("ff", 8'hE1, 1'b0, 1'b0, carry);
        chk("ff_carry_seen", 32'(carry), 32'd1);
        @(negedge clk);
        chk("ff_hold", 32'(product), 32'hE1);

        single_op("a_x3", 4'hA, 4'h3, 1'b0);
        single_op("z_x9", 4'h0, 4'h9, 1'b0);
        single_op("7_xz", 4'h7, 4'h0, 1'b0);

        // Back-to-back: second start presented in the DONE cycle.
        launch(4'h2, 4'h4);
        run_body("b2b1", 8'h08, 1'b0, 1'b0, carry);
        launch(4'h3, 4'h5);
        run_body("b2b2", 8'h0F, 1'b0, 1'b0, carry);
        @(negedge clk);
        chk("b2b_idle", 32'(busy), 32'd0);
        chk("b2b_hold", 32'(product), 32'h0F);

        // start poked mid-run with complemented operands must be ignored.
        single_op("mid", 4'h6, 4'hB, 1'b1);

        // Reset during the second RUN cycle.
        launch(4'h9, 4'h6);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_product", 32'(product), 32'd0);
        chk("mrst_num1", 32'(add_num1), 32'd0);
        chk("mrst_num2", 32'(add_num2), 32'd0);
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            chk("mrst_nodone", 32'(done), 32'd0);
        end
        single_op("p5x5", 4'h5, 4'h5, 1'b0);

        // rst and start on the same edge: reset wins.
        rst = 1'b1;
        launch(4'h3, 4'h3);
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        chk("rststart_busy", 32'(busy), 32'd0);
        chk("rststart_product", 32'(product), 32'd0);

        // start held high continuously: a result every WIDTH+1 cycles, operands resampled.
        launch(4'hC, 4'hD);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            logic [2*WIDTH-1:0] exp_hold;
            exp_hold = (2*WIDTH)'(a) * (2*WIDTH)'(b);
            for (int i = 0; i < WIDTH; i++) begin
                @(negedge clk);
                chk("hold_busy", 32'(busy), 32'd1);
                a = 4'(k * 5 + i + 1);
                b = 4'(15 - k * 3 - i);
                @(posedge clk);
            end
            @(negedge clk);
            chk("hold_done", 32'(done), 32'd1);
            chk("hold_product", 32'(product), 32'(exp_hold));
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);

        // Random operands against plain multiplication.
        for (int n = 0; n < 24; n++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            single_op("rand", ra, rb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
